// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared fp16 significand widths, multiplier state type and iteration count
package fp16_pkg;

  localparam int FP16_FRAC_W = 10;
  localparam int FP16_MANT_W = 11;
  localparam int FP16_PROD_W = 22;
  localparam int MULT_ITERS  = FP16_MANT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/fp16_mant_mult_seq_mult_step.sv
// rtl/fp16_mant_mult_seq_mult_step.sv - one radix-2 add-and-shift iteration
module mult_step #(
  parameter int W = 11
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] mplier,
  input  logic [W-1:0] mcand,
  output logic [W-1:0] acc_nxt,
  output logic [W-1:0] mplier_nxt
);

  logic [W:0] sum;

  // The carry of the add becomes the new MSB after the right shift; the bit
  // shifted out of acc moves into the vacated top of the multiplier register.
  always_comb begin
    sum = {1'b0, acc};
    if (mplier[0]) begin
      sum = {1'b0, acc} + {1'b0, mcand};
    end
    acc_nxt    = sum[W:1];
    mplier_nxt = {sum[0], mplier[W-1:1]};
  end

endmodule

// File: rtl/fp16_mant_mult_seq.sv
// rtl/fp16_mant_mult_seq.sv - sequential shift-add fp16 significand multiplier with valid/ready
module fp16_mant_mult_seq
  import fp16_pkg::*;
#(
  parameter int FRAC_W     = FP16_FRAC_W,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FRAC_W-1:0]       in_a_frac,
  input  logic                    in_a_hid,
  input  logic [FRAC_W-1:0]       in_b_frac,
  input  logic                    in_b_hid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*(FRAC_W+1)-1:0] out_product
);

  localparam int MANT_W = FRAC_W + 1;
  localparam int CNT_W  = $clog2(MANT_W);

  mult_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MANT_W-1:0] acc_q, acc_d;
  logic [MANT_W-1:0] mplier_q, mplier_d;
  logic [MANT_W-1:0] mcand_q, mcand_d;
  logic [MANT_W-1:0] acc_step, mplier_step;
  logic [MANT_W-1:0] op_a, op_b;
  logic              zero_op;

  assign op_a    = {in_a_hid, in_a_frac};
  assign op_b    = {in_b_hid, in_b_frac};
  assign zero_op = EARLY_ZERO && ((op_a == '0) || (op_b == '0));

  mult_step #(.W(MANT_W)) u_step (
    .acc        (acc_q),
    .mplier     (mplier_q),
    .mcand      (mcand_q),
    .acc_nxt    (acc_step),
    .mplier_nxt (mplier_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = '0;
          // A zero operand leaves {acc, mplier} all-zero, which is the product.
          if (zero_op) begin
            mplier_d = '0;
            state_d  = DONE;
          end else begin
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        acc_d    = acc_step;
        mplier_d = mplier_step;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MANT_W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // After the last shift the multiplier register holds the low product half.
  assign out_product = {acc_q, mplier_q};

endmodule

// File: tb/tb_fp16_mant_mult_seq.sv
// tb/tb_fp16_mant_mult_seq.sv - directed and table-driven bench for fp16_mant_mult_seq
module tb_fp16_mant_mult_seq;
  import fp16_pkg::*;

  typedef struct {
    logic [10:0] a;
    logic [10:0] b;
    logic [21:0] exp_prod;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid1 = 1'b0, in_valid2 = 1'b0;
  logic        in_ready1, in_ready2;
  logic [9:0]  in_a_frac = '0, in_b_frac = '0;
  logic        in_a_hid = 1'b0, in_b_hid = 1'b0;
  logic        out_valid1, out_valid2;
  logic        out_ready = 1'b0;
  logic [FP16_PROD_W-1:0] out_product1, out_product2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp16_mant_mult_seq #(.FRAC_W(10), .EARLY_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a_frac(in_a_frac), .in_a_hid(in_a_hid), .in_b_frac(in_b_frac), .in_b_hid(in_b_hid),
    .out_valid(out_valid1), .out_ready(out_ready), .out_product(out_product1)
  );

  fp16_mant_mult_seq #(.FRAC_W(10), .EARLY_ZERO(1'b0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a_frac(in_a_frac), .in_a_hid(in_a_hid), .in_b_frac(in_b_frac), .in_b_hid(in_b_hid),
    .out_valid(out_valid2), .out_ready(out_ready), .out_product(out_product2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_ops(input logic [10:0] a, input logic [10:0] b);
    in_a_hid  = a[10];
    in_a_frac = a[9:0];
    in_b_hid  = b[10];
    in_b_frac = b[9:0];
  endtask

  task automatic wait_valid(input bit sel, output int lat);
    lat = 0;
    while (!(sel ? out_valid2 : out_valid1) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input bit sel, input logic [10:0] a, input logic [10:0] b,
                        output logic [21:0] prod, output int lat);
    drive_ops(a, b);
    if (sel) in_valid2 = 1'b1; else in_valid1 = 1'b1;
    chk("in_ready_idle", sel ? in_ready2 : in_ready1, 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
    drive_ops(11'($urandom), 11'($urandom));
    wait_valid(sel, lat);
    prod = sel ? out_product2 : out_product1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("handoff_out_valid", sel ? out_valid2 : out_valid1, 0);
    chk("handoff_in_ready", sel ? in_ready2 : in_ready1, 1);
  endtask

  vec_t        vecs[12];
  logic [21:0] prod;
  int          lat;
  logic [10:0] ra, rb;

  initial begin
    vecs[0]  = '{11'h400, 11'h400, 22'h100000};
    vecs[1]  = '{11'h600, 11'h600, 22'h240000};
    vecs[2]  = '{11'h7FF, 11'h7FF, 22'h3FF001};
    vecs[3]  = '{11'h400, 11'h600, 22'h180000};
    vecs[4]  = '{11'h001, 11'h7FF, 22'h0007FF};
    vecs[5]  = '{11'h7FF, 11'h001, 22'h0007FF};
    vecs[6]  = '{11'h555, 11'h2AA, 22'h0E3472};
    vecs[7]  = '{11'h401, 11'h401, 22'h100801};
    vecs[8]  = '{11'h000, 11'h5A5, 22'h000000};
    vecs[9]  = '{11'h5A5, 11'h000, 22'h000000};
    vecs[10] = '{11'h7FF, 11'h400, 22'h1FFC00};
    vecs[11] = '{11'h3FF, 11'h3FF, 22'h0FF801};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready1, 1);
    chk("reset_out_valid", out_valid1, 0);
    chk("reset_out_product", out_product1, 0);
    chk("reset_out_product_nz", out_product2, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_op(1'b0, vecs[i].a, vecs[i].b, prod, lat);
      chk($sformatf("vec%0d_product", i), prod, vecs[i].exp_prod);
      chk($sformatf("vec%0d_latency", i), lat,
          (vecs[i].a == 0 || vecs[i].b == 0) ? 0 : MULT_ITERS);
    end

    run_op(1'b1, 11'h000, 11'h5A5, prod, lat);
    chk("nz_zero_product", prod, 0);
    chk("nz_zero_latency", lat, MULT_ITERS);

    // Backpressure: result held while the consumer stalls, new operands refused.
    drive_ops(11'h600, 11'h600);
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    wait_valid(1'b0, lat);
    chk("bp_latency", lat, MULT_ITERS);
    for (int c = 0; c < 5; c++) begin
      in_valid1 = 1'b1;
      drive_ops(11'($urandom), 11'($urandom));
      @(posedge clk); #1;
      chk($sformatf("bp%0d_product", c), out_product1, 22'h240000);
      chk($sformatf("bp%0d_out_valid", c), out_valid1, 1);
      chk($sformatf("bp%0d_in_ready", c), in_ready1, 0);
    end
    in_valid1 = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_out_valid", out_valid1, 0);
    chk("bp_release_in_ready", in_ready1, 1);

    // Reset in the middle of an iteration sequence.
    drive_ops(11'h7FF, 11'h7FF);
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midbusy_in_ready", in_ready1, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid1, 0);
    chk("midrst_in_ready", in_ready1, 1);
    chk("midrst_out_product", out_product1, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b0, 11'h400, 11'h600, prod, lat);
    chk("postrst_product", prod, 22'h180000);
    chk("postrst_latency", lat, MULT_ITERS);

    for (int r = 0; r < 200; r++) begin
      ra = 11'($urandom_range(0, 2047));
      rb = 11'($urandom_range(0, 2047));
      if (r % 50 == 0) ra = 11'h0;
      run_op(1'b0, ra, rb, prod, lat);
      chk($sformatf("rand%0d_product", r), prod, 22'(ra) * 22'(rb));
      chk($sformatf("rand%0d_latency", r), lat, (ra == 0 || rb == 0) ? 0 : MULT_ITERS);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
